// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic        fault;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a flush with a simultaneous push leaves only the pushed entry.
module fetch_fifo #(
   parameter int             DEPTH   = 2,
   parameter int             W       = 65,
   parameter logic [W-1:0]   RST_VAL = '0,
   parameter int             CW      = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           rptr, wptr;
   logic [CW-1:0]           cnt;
   logic                    pop_ok;

   assign pop_ok = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem  <= {DEPTH{RST_VAL}};
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         rptr <= '0;
         wptr <= push ? AW'(1) : '0;
         cnt  <= push ? CW'(1) : '0;
         if (push) mem[0] <= push_data;
      end else begin
         if (push) mem[wptr] <= push_data;
         wptr <= wptr + AW'(push);
         rptr <= rptr + AW'(pop_ok);
         cnt  <= cnt + CW'(push) - CW'(pop_ok);
      end
   end

   assign head  = mem[rptr];
   assign count = cnt;
   assign full  = cnt == CW'(DEPTH);
   assign empty = cnt == '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers responses
// and handles redirects by flushing the buffer and dropping stale in-flight responses.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_VECTOR,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instruction,
   output logic [31:0] id_pc,
   output logic        id_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic {FETCH, FAULT} state_e;

   state_e        state;
   logic          armed;
   logic [31:0]   fetch_pc, resp_pc;
   logic [CW-1:0] outstanding, drop_cnt, fifo_count;
   logic [CW:0]   credit_used;
   logic          fifo_full, fifo_empty;
   logic          req_fire, resp_keep, mis, push, pop;
   fetch_entry_t  push_entry, head;

   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = armed && state == FETCH && !redirect_valid &&
                           credit_used < (CW+1)'(FIFO_DEPTH);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_keep      = imem_resp_valid && drop_cnt == '0 && !redirect_valid;
   assign mis            = misaligned(redirect_pc);
   assign pop            = id_valid && id_ready;
   assign push           = redirect_valid ? mis : resp_keep;

   always_comb begin
      push_entry = '{fault: 1'b0, pc: resp_pc, instr: imem_resp_data};
      if (redirect_valid)
         push_entry = '{fault: 1'b1, pc: redirect_pc, instr: NOP_INSTR};
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .W       (ENTRY_W),
      .RST_VAL ({1'b0, RESET_PC, NOP_INSTR}),
      .CW      (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign id_valid       = !fifo_empty;
   assign id_instruction = head.instr;
   assign id_pc          = head.pc;
   assign id_fault       = head.fault;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         armed       <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         armed       <= 1'b1;
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
         if (redirect_valid) begin
            state    <= mis ? FAULT : FETCH;
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            // Every in-flight request is stale now; outstanding already counts pending drops.
            drop_cnt <= outstanding - CW'(imem_resp_valid);
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
            if (resp_keep) resp_pc  <= resp_pc + 32'd4;
            if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst)
         assert (!(push && !redirect_valid && fifo_full && !pop))
            else $error("fetch_fifo overflow: push into full buffer");
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized stimulus for fetch_unit against a stream-level reference model.
module tb_fetch_unit;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          DEPTH = 2;

   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready, imem_resp_valid;
   logic [31:0] imem_req_addr, imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready, id_fault;
   logic [31:0] id_instruction, id_pc;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
      .id_instruction(id_instruction), .id_pc(id_pc), .id_fault(id_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;

   req_t        mq[$];
   int          checks, errors, cyc, pops;
   int          buffered;
   bit          fault_mode;
   logic [31:0] tgt, exp_req_pc, exp_dec_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      buffered   = 0;
      fault_mode = 0;
      tgt        = 32'h0;
      exp_req_pc = 32'h0;
      exp_dec_pc = 32'h0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      chk({tag, "_req_addr"},  imem_req_addr, 32'h0);
      chk({tag, "_id_valid"},  32'(id_valid), 32'd0);
      chk({tag, "_id_instr"},  id_instruction, NOP);
      chk({tag, "_id_pc"},     id_pc, 32'h0);
      chk({tag, "_id_fault"},  32'(id_fault), 32'd0);
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit rd, input logic [31:0] rpc, input bit idr,
                       input bit rqr, input int lat);
      req_t e;
      @(posedge clk); #1;
      cyc++;
      redirect_valid = rd;
      redirect_pc    = rpc;
      id_ready       = idr;
      imem_req_ready = rqr;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memf(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      #1;
      chk("id_valid", 32'(id_valid), 32'(buffered > 0));
      if (id_valid) begin
         if (fault_mode) begin
            chk("fault_pc", id_pc, tgt);
            chk("fault_instr", id_instruction, NOP);
            chk("fault_flag", 32'(id_fault), 32'd1);
         end else begin
            chk("id_pc", id_pc, exp_dec_pc);
            chk("id_instr", id_instruction, memf(exp_dec_pc));
            chk("id_fault", 32'(id_fault), 32'd0);
         end
      end
      if (imem_req_valid) begin
         chk("req_allowed", 32'(!rd && !fault_mode && (mq.size() + buffered) < DEPTH), 32'd1);
         chk("req_addr", imem_req_addr, exp_req_pc);
      end
      if (id_valid && idr) begin
         pops++;
         buffered--;
         if (!fault_mode) exp_dec_pc += 32'd4;
      end
      if (imem_req_valid && rqr) begin
         e.addr = imem_req_addr; e.stale = 0; e.due = cyc + lat;
         mq.push_back(e);
         exp_req_pc += 32'd4;
      end
      if (imem_resp_valid) begin
         e = mq.pop_front();
         if (!e.stale && !rd) buffered++;
      end
      if (rd) begin
         foreach (mq[i]) mq[i].stale = 1;
         fault_mode = rpc[1:0] != 2'b00;
         buffered   = fault_mode ? 1 : 0;
         tgt        = rpc;
         exp_req_pc = rpc;
         exp_dec_pc = rpc;
      end
   endtask

   initial begin
      logic [31:0] rpc;
      int          r;
      checks = 0; errors = 0; cyc = 0; pops = 0;
      rst = 1'b1;
      imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
      redirect_valid = 0; redirect_pc = '0; id_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst = 1'b0;

      // steady stream, latency 1
      repeat (12) step(0, 0, 1, 1, 1);
      // backpressure then drain
      repeat (10) step(0, 0, 0, 1, 1);
      repeat (10) step(0, 0, 1, 1, 1);
      // redirect while responses are in flight and one arrives in the same cycle
      repeat (4) step(0, 0, 1, 1, 3);
      step(1, 32'h100, 1, 1, 3);
      repeat (12) step(0, 0, 1, 1, 3);
      repeat (6) step(0, 0, 1, 1, 1);
      step(1, 32'h40, 1, 1, 1);
      repeat (8) step(0, 0, 1, 1, 1);
      // misaligned redirect holds a fault entry and stops fetching
      step(1, 32'h102, 0, 1, 2);
      repeat (6) step(0, 0, 0, 1, 1);
      repeat (4) step(0, 0, 1, 1, 1);
      step(1, 32'h200, 1, 1, 1);
      repeat (10) step(0, 0, 1, 1, 1);
      // address wrap
      step(1, 32'hFFFF_FFF8, 1, 1, 1);
      repeat (12) step(0, 0, 1, 1, 2);

      repeat (3000) begin
         r = $urandom_range(0, 9);
         if (r == 0)      rpc = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
         else if (r == 1) rpc = 32'hFFFF_FFF0;
         else             rpc = {20'h0, $urandom_range(0, 1023), 2'b00};
         step($urandom_range(0, 29) == 0, rpc, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(1, 4));
      end
      // make sure fetching resumes before the mid-stream reset
      step(1, 32'h300, 1, 1, 1);
      repeat (6) step(0, 0, 1, 1, 1);

      @(posedge clk); #3;
      rst = 1'b1;
      redirect_valid = 0; imem_resp_valid = 0; id_ready = 0; imem_req_ready = 0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) step(0, 0, 1, 1, 1);

      chk("progress", 32'(pops > 500), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
